// File: rtl/ysyx_22050243_id_ex_ff.sv
// ID/EX pipeline register: carries decoded operands and control bits into EX,
// with flush/hold/bubble handling and saturating bubble/flush event counters.
module ysyx_22050243_id_ex_ff #(
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int XLEN           = 64,
    parameter int ALUOP_WIDTH    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [XLEN-1:0]           id_pc,
    input  logic [XLEN-1:0]           id_rs1_data,
    input  logic [XLEN-1:0]           id_rs2_data,
    input  logic [XLEN-1:0]           id_imm,
    input  logic [GPR_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_rd_wen,
    input  logic                      id_mem_r,
    input  logic                      id_mem_w,
    input  logic                      id_csr_r,
    input  logic [ALUOP_WIDTH-1:0]    id_alu_op,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      ex_ready,
    output logic                      id_ready,
    output logic                      ex_valid,
    output logic [XLEN-1:0]           ex_pc,
    output logic [XLEN-1:0]           ex_rs1_data,
    output logic [XLEN-1:0]           ex_rs2_data,
    output logic [XLEN-1:0]           ex_imm,
    output logic [GPR_ADDR_WIDTH-1:0] rd_id_2_ex_ff,
    output logic                      ex_rd_wen,
    output logic                      mem_r_id_2_ex_ff,
    output logic                      ex_mem_w,
    output logic                      csr_r_id_2_ex_ff,
    output logic [ALUOP_WIDTH-1:0]    ex_alu_op,
    output logic [31:0]               bubble_cnt,
    output logic [31:0]               flush_cnt
);

    typedef struct packed {
        logic                      valid;
        logic [GPR_ADDR_WIDTH-1:0] rd;
        logic                      rd_wen;
        logic                      mem_r;
        logic                      mem_w;
        logic                      csr_r;
        logic [ALUOP_WIDTH-1:0]    alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
    } data_t;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } action_e;

    ctrl_t       ctrl_q, ctrl_d, id_ctrl;
    data_t       data_q, data_d, id_data;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    action_e     action;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign id_ready = ex_ready & ~stall & ~flush;

    // Flush outranks hold so a redirect kills the EX slot even while EX is busy.
    always_comb begin
        if (flush)          action = ACT_FLUSH;
        else if (!ex_ready) action = ACT_HOLD;
        else if (stall)     action = ACT_BUBBLE;
        else                action = ACT_LOAD;
    end

    // An invalid decode slot loads as all-zero control so no stale rd reaches the hazard unit.
    always_comb begin
        id_ctrl        = '0;
        id_data.pc     = id_pc;
        id_data.rs1    = id_rs1_data;
        id_data.rs2    = id_rs2_data;
        id_data.imm    = id_imm;
        if (id_valid) begin
            id_ctrl.valid  = 1'b1;
            id_ctrl.rd     = id_rd;
            id_ctrl.rd_wen = id_rd_wen;
            id_ctrl.mem_r  = id_mem_r;
            id_ctrl.mem_w  = id_mem_w;
            id_ctrl.csr_r  = id_csr_r;
            id_ctrl.alu_op = id_alu_op;
        end
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        unique case (action)
            ACT_FLUSH: begin
                ctrl_d      = '0;
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
            ACT_HOLD: begin
            end
            ACT_BUBBLE: begin
                ctrl_d       = '0;
                bubble_cnt_d = sat_inc(bubble_cnt_q);
            end
            ACT_LOAD: begin
                ctrl_d = id_ctrl;
                data_d = id_data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q       <= '0;
            data_q       <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid         = ctrl_q.valid;
    assign rd_id_2_ex_ff    = ctrl_q.rd;
    assign ex_rd_wen        = ctrl_q.rd_wen;
    assign mem_r_id_2_ex_ff = ctrl_q.mem_r;
    assign ex_mem_w         = ctrl_q.mem_w;
    assign csr_r_id_2_ex_ff = ctrl_q.csr_r;
    assign ex_alu_op        = ctrl_q.alu_op;
    assign ex_pc            = data_q.pc;
    assign ex_rs1_data      = data_q.rs1;
    assign ex_rs2_data      = data_q.rs2;
    assign ex_imm           = data_q.imm;
    assign bubble_cnt       = bubble_cnt_q;
    assign flush_cnt        = flush_cnt_q;

`ifndef SYNTHESIS
    a_ctrl_zero_when_invalid : assert property (
        @(posedge clk) disable iff (rst) !ctrl_q.valid |-> (ctrl_q == '0));
`endif

endmodule

// File: tb/tb_ysyx_22050243_id_ex_ff.sv
// Bench for the ID/EX register: a behavioural model predicts the registered
// outputs each cycle; predictions are queued at drive time and checked after the edge.
module tb_ysyx_22050243_id_ex_ff;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_r;
        logic        mem_w;
        logic        csr_r;
        logic [4:0]  alu_op;
        logic [31:0] bcnt;
        logic [31:0] fcnt;
    } st_t;

    localparam int SB_W = $bits(st_t);

    logic        clk, rst;
    logic        id_valid;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rd;
    logic        id_rd_wen, id_mem_r, id_mem_w, id_csr_r;
    logic [4:0]  id_alu_op;
    logic        stall, flush, ex_ready;
    logic        id_ready, ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  rd_id_2_ex_ff;
    logic        ex_rd_wen, mem_r_id_2_ex_ff, ex_mem_w, csr_r_id_2_ex_ff;
    logic [4:0]  ex_alu_op;
    logic [31:0] bubble_cnt, flush_cnt;

    logic [SB_W-1:0] exp_q[$];
    st_t             model;
    int              n_checks = 0;
    int              n_errors = 0;

    ysyx_22050243_id_ex_ff dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
        .id_csr_r(id_csr_r), .id_alu_op(id_alu_op),
        .stall(stall), .flush(flush), .ex_ready(ex_ready), .id_ready(id_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .rd_id_2_ex_ff(rd_id_2_ex_ff),
        .ex_rd_wen(ex_rd_wen), .mem_r_id_2_ex_ff(mem_r_id_2_ex_ff), .ex_mem_w(ex_mem_w),
        .csr_r_id_2_ex_ff(csr_r_id_2_ex_ff), .ex_alu_op(ex_alu_op),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [SB_W-1:0] obs, input logic [SB_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [SB_W-1:0] dut_state();
        st_t o;
        o.valid  = ex_valid;
        o.pc     = ex_pc;
        o.rs1    = ex_rs1_data;
        o.rs2    = ex_rs2_data;
        o.imm    = ex_imm;
        o.rd     = rd_id_2_ex_ff;
        o.rd_wen = ex_rd_wen;
        o.mem_r  = mem_r_id_2_ex_ff;
        o.mem_w  = ex_mem_w;
        o.csr_r  = csr_r_id_2_ex_ff;
        o.alu_op = ex_alu_op;
        o.bcnt   = bubble_cnt;
        o.fcnt   = flush_cnt;
        return o;
    endfunction

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic st_t clear_ctrl(input st_t s);
        st_t r = s;
        r.valid = 1'b0; r.rd = '0; r.rd_wen = 1'b0; r.mem_r = 1'b0;
        r.mem_w = 1'b0; r.csr_r = 1'b0; r.alu_op = '0;
        return r;
    endfunction

    // Reference behaviour of one clock edge given the currently driven inputs.
    function automatic st_t model_step(input st_t s);
        st_t r = s;
        if (flush) begin
            r = clear_ctrl(s);
            r.fcnt = sat1(s.fcnt);
        end else if (!ex_ready) begin
            r = s;
        end else if (stall) begin
            r = clear_ctrl(s);
            r.bcnt = sat1(s.bcnt);
        end else begin
            r.pc = id_pc; r.rs1 = id_rs1_data; r.rs2 = id_rs2_data; r.imm = id_imm;
            if (id_valid) begin
                r.valid = 1'b1; r.rd = id_rd; r.rd_wen = id_rd_wen; r.mem_r = id_mem_r;
                r.mem_w = id_mem_w; r.csr_r = id_csr_r; r.alu_op = id_alu_op;
            end else begin
                r = clear_ctrl(r);
            end
        end
        return r;
    endfunction

    task automatic rand_id();
        id_valid    = ($urandom_range(0, 4) != 0);
        id_pc       = {$urandom, $urandom};
        id_rs1_data = {$urandom, $urandom};
        id_rs2_data = {$urandom, $urandom};
        id_imm      = {$urandom, $urandom};
        id_rd       = 5'($urandom_range(0, 31));
        id_rd_wen   = 1'($urandom_range(0, 1));
        id_mem_r    = 1'($urandom_range(0, 1));
        id_mem_w    = 1'($urandom_range(0, 1));
        id_csr_r    = 1'($urandom_range(0, 1));
        id_alu_op   = 5'($urandom_range(0, 31));
    endtask

    // Driver: called in the low clock phase with id_* already set.
    task automatic cycle(input string tag, input logic st, input logic fl, input logic rdy);
        logic [SB_W-1:0] exp;
        stall = st; flush = fl; ex_ready = rdy;
        #1;
        check({tag, ".id_ready"}, SB_W'(id_ready), SB_W'(rdy & ~st & ~fl));
        model = model_step(model);
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".sb_empty"}, SB_W'(1), SB_W'(0));
        end else begin
            exp = exp_q.pop_front();
            check(tag, dut_state(), exp);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        rand_id();
        model = '0;
        #2;
        check("reset_state", dut_state(), SB_W'(0));
        check("reset_id_ready", SB_W'(id_ready), SB_W'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed load then load-use bubble.
        id_valid = 1'b1; id_rd = 5'd5; id_mem_r = 1'b1; id_pc = 64'h8000_0000;
        id_rd_wen = 1'b1; id_mem_w = 1'b0; id_csr_r = 1'b0; id_alu_op = 5'd3;
        cycle("load", 1'b0, 1'b0, 1'b1);
        check("load.ex_pc", SB_W'(ex_pc), SB_W'(64'h8000_0000));
        check("load.rd", SB_W'(rd_id_2_ex_ff), SB_W'(5));
        rand_id(); id_valid = 1'b1;
        cycle("load_use_bubble", 1'b1, 1'b0, 1'b1);
        check("bubble.cnt", SB_W'(bubble_cnt), SB_W'(1));
        check("bubble.valid", SB_W'(ex_valid), SB_W'(0));
        cycle("after_bubble_load", 1'b0, 1'b0, 1'b1);

        // Hold with stall and changing decode inputs.
        for (int i = 0; i < 3; i++) begin
            rand_id();
            cycle("hold", 1'b1, 1'b0, 1'b0);
        end
        check("hold.bcnt", SB_W'(bubble_cnt), SB_W'(1));

        // Flush and stall in the same cycle.
        rand_id();
        cycle("flush_stall", 1'b1, 1'b1, 1'b1);
        check("flush_stall.fcnt", SB_W'(flush_cnt), SB_W'(1));
        check("flush_stall.bcnt", SB_W'(bubble_cnt), SB_W'(1));

        // Invalid decode slot loads zero control.
        rand_id(); id_valid = 1'b0; id_rd = 5'd9; id_rd_wen = 1'b1;
        cycle("load_invalid", 1'b0, 1'b0, 1'b1);

        // Back-to-back stalls.
        for (int i = 0; i < 3; i++) begin
            rand_id();
            cycle("b2b_stall", 1'b1, 1'b0, 1'b1);
        end

        for (int i = 0; i < 200; i++) begin
            rand_id();
            cycle("random", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 4) != 0));
        end

        // Asynchronous reset between edges.
        rand_id(); id_valid = 1'b1; id_rd = 5'd7;
        cycle("pre_reset_load", 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model = '0;
        check("async_reset", dut_state(), SB_W'(0));
        check("reset_id_ready2", SB_W'(id_ready), SB_W'(1));
        @(negedge clk);
        rst = 1'b0;
        rand_id(); id_valid = 1'b1;
        cycle("post_reset_load", 1'b0, 1'b0, 1'b1);

        // Counter saturation from a preloaded near-max value.
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        force dut.flush_cnt_q  = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt_q;
        release dut.flush_cnt_q;
        model.bcnt = 32'hFFFF_FFFE;
        model.fcnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 2; i++) begin
            rand_id();
            cycle("sat_stall", 1'b1, 1'b0, 1'b1);
            cycle("sat_flush", 1'b0, 1'b1, 1'b1);
        end
        check("sat.bcnt", SB_W'(bubble_cnt), SB_W'(32'hFFFF_FFFF));
        check("sat.fcnt", SB_W'(flush_cnt), SB_W'(32'hFFFF_FFFF));

        check("sb_drained", SB_W'(exp_q.size()), SB_W'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
